// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: datapath plus control FSM, one ready-handshaked unified memory port,
// halt on illegal opcode/funct, and a retired-instruction counter.
module multicycle_core #(
    parameter int                DATA_W    = 32,
    parameter int                REG_COUNT = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_halted,
    output logic [DATA_W-1:0] o_retired,
    output logic [DATA_W-1:0] o_pc_dbg
);

    localparam int                REG_AW  = $clog2(REG_COUNT);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(DATA_W / 8);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_BRANCH, S_JUMP, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_retired;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_rf [REG_COUNT];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_funct_ok;
    logic              w_legal;

    logic              w_mem_rd;
    logic              w_mem_wr;
    logic              w_addr_pc;
    logic              w_ir_we;
    logic              w_pc_we;
    logic [DATA_W-1:0] w_pc_nx;
    logic              w_ab_we;
    logic              w_alu_we;
    logic [DATA_W-1:0] w_alu_nx;
    logic              w_mdr_we;
    logic              w_rf_we;
    logic [REG_AW-1:0] w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;
    logic              w_retire;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_rs     = r_ir[21 +: REG_AW];
    assign w_rt     = r_ir[16 +: REG_AW];
    assign w_rd     = r_ir[11 +: REG_AW];
    assign w_simm   = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
    assign w_rs_val = (w_rs == '0) ? '0 : r_rf[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 : r_rf[w_rt];

    always_comb begin
        w_alu_res = '0;
        case (w_funct)
            FN_ADD:  w_alu_res = r_a + r_b;
            FN_SUB:  w_alu_res = r_a - r_b;
            FN_AND:  w_alu_res = r_a & r_b;
            FN_OR:   w_alu_res = r_a | r_b;
            FN_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_funct_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) || (w_funct == FN_AND) ||
                     (w_funct == FN_OR)  || (w_funct == FN_SLT);
        case (w_op)
            OP_RTYPE:                          w_legal = w_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_legal = 1'b1;
            default:                           w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_FETCH;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_addr_pc  = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_nx    = r_pc;
        w_ab_we    = 1'b0;
        w_alu_we   = 1'b0;
        w_alu_nx   = r_alu;
        w_mdr_we   = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rt;
        w_rf_wdata = r_alu;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_rd  = 1'b1;
                w_addr_pc = 1'b1;
                if (i_mem_ready) begin
                    w_ir_we    = 1'b1;
                    w_pc_we    = 1'b1;
                    w_pc_nx    = r_pc + PC_STEP;
                    w_state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here from the already-incremented PC
                w_ab_we  = 1'b1;
                w_alu_we = 1'b1;
                w_alu_nx = r_pc + (w_simm << 2);
                if (!w_legal) begin
                    w_state_nx = S_HALT;
                end else begin
                    case (w_op)
                        OP_BEQ:       w_state_nx = S_BRANCH;
                        OP_J:         w_state_nx = S_JUMP;
                        OP_LW, OP_SW: w_state_nx = S_MEMADR;
                        OP_ADDI:      w_state_nx = S_ADDIEX;
                        default:      w_state_nx = S_EXEC;
                    endcase
                end
            end
            S_BRANCH: begin
                if (r_a == r_b) begin
                    w_pc_we = 1'b1;
                    w_pc_nx = r_alu;
                end
                w_retire   = 1'b1;
                w_state_nx = S_FETCH;
            end
            S_JUMP: begin
                w_pc_we    = 1'b1;
                w_pc_nx    = {r_pc[DATA_W-1:28], r_ir[25:0], 2'b00};
                w_retire   = 1'b1;
                w_state_nx = S_FETCH;
            end
            S_MEMADR: begin
                w_alu_we   = 1'b1;
                w_alu_nx   = r_a + w_simm;
                w_state_nx = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_rd = 1'b1;
                if (i_mem_ready) begin
                    w_mdr_we   = 1'b1;
                    w_state_nx = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rt;
                w_rf_wdata = r_mdr;
                w_retire   = 1'b1;
                w_state_nx = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_wr = 1'b1;
                if (i_mem_ready) begin
                    w_retire   = 1'b1;
                    w_state_nx = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_we   = 1'b1;
                w_alu_nx   = w_alu_res;
                w_state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rd;
                w_retire   = 1'b1;
                w_state_nx = S_FETCH;
            end
            S_ADDIEX: begin
                w_alu_we   = 1'b1;
                w_alu_nx   = r_a + w_simm;
                w_state_nx = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rt;
                w_retire   = 1'b1;
                w_state_nx = S_FETCH;
            end
            S_HALT: begin
                w_state_nx = S_HALT;
            end
            default: begin
                w_state_nx = S_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_retired <= '0;
            for (int i = 0; i < REG_COUNT; i++) r_rf[i] <= '0;
        end else begin
            if (w_ir_we)  r_ir  <= i_mem_rdata[31:0];
            if (w_pc_we)  r_pc  <= w_pc_nx;
            if (w_ab_we) begin
                r_a <= w_rs_val;
                r_b <= w_rt_val;
            end
            if (w_alu_we) r_alu <= w_alu_nx;
            if (w_mdr_we) r_mdr <= i_mem_rdata;
            // r0 is never written so it stays hard zero
            if (w_rf_we && (w_rf_waddr != '0)) r_rf[w_rf_waddr] <= w_rf_wdata;
            if (w_retire) r_retired <= r_retired + ONE;
        end
    end

    assign o_mem_rd    = w_mem_rd & ~i_reset;
    assign o_mem_wr    = w_mem_wr & ~i_reset;
    assign o_mem_addr  = w_addr_pc ? r_pc : r_alu;
    assign o_mem_wdata = r_b;
    assign o_halted    = (r_state == S_HALT) & ~i_reset;
    assign o_retired   = r_retired;
    assign o_pc_dbg    = r_pc;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs plus a random program, each instruction checked
// against an instruction-level reference model (registers, PC, memory, cycle count, retire count).
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        halted;
    logic [31:0] retired;
    logic [31:0] pc_dbg;

    multicycle_core #(.DATA_W(32), .REG_COUNT(32), .RESET_PC(32'h0)) dut (
        .i_clk(clk), .i_reset(reset), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready),
        .o_halted(halted), .o_retired(retired), .o_pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          waits  = 0;
    int          wcnt   = 0;
    logic [31:0] mem   [1024];
    logic [31:0] m_mem [1024];
    logic [31:0] m_r   [32];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: 'waits' not-ready cycles before each transfer, garbage data otherwise
    logic        p_pend = 1'b0;
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_wdata;
    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'h0);
            if (p_pend) begin
                chk("req_stable_rd", {31'b0, mem_rd}, {31'b0, p_rd});
                chk("req_stable_wr", {31'b0, mem_wr}, {31'b0, p_wr});
                chk("req_stable_addr", mem_addr, p_addr);
                if (p_wr) chk("req_stable_wdata", mem_wdata, p_wdata);
            end
        end
        if (reset || !(mem_rd || mem_wr)) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            mem_rdata = $urandom;
        end else if (wcnt < waits) begin
            mem_ready = 1'b0;
            wcnt++;
            mem_rdata = $urandom;
        end else begin
            mem_ready = 1'b1;
            wcnt      = 0;
            if (mem_rd) mem_rdata = mem[mem_addr[11:2]];
            if (mem_wr) mem[mem_addr[11:2]] = mem_wdata;
        end
        p_pend  = !reset && (mem_rd || mem_wr) && !mem_ready;
        p_rd    = mem_rd;
        p_wr    = mem_wr;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = '0;
        for (int i = 0; i < 1024; i++) m_mem[i] = mem[i];
        m_pc  = '0;
        m_ret = '0;
    endtask

    // Instruction-level ISA model; cycle cost is base cycles plus 'waits' per memory access
    task automatic model_step(output int cyc, output bit halt, output bit is_st,
                              output logic [31:0] st_addr);
        logic [31:0] ir, a, b, simm, npc, res, ea;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        ir   = m_mem[m_pc[11:2]];
        op   = ir[31:26];
        rs   = ir[25:21];
        rt   = ir[20:16];
        rd   = ir[15:11];
        fn   = ir[5:0];
        a    = m_r[rs];
        b    = m_r[rt];
        simm = {{16{ir[15]}}, ir[15:0]};
        npc  = m_pc + 32'd4;
        res  = '0;
        ea   = '0;
        halt = 1'b0;
        is_st = 1'b0;
        st_addr = '0;
        cyc  = 0;
        case (op)
            6'h00: begin
                cyc = 4 + waits;
                case (fn)
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: halt = 1'b1;
                endcase
                if (!halt && rd != 5'd0) m_r[rd] = res;
            end
            6'h08: begin
                cyc = 4 + waits;
                if (rt != 5'd0) m_r[rt] = a + simm;
            end
            6'h23: begin
                cyc = 5 + 2 * waits;
                ea  = a + simm;
                if (rt != 5'd0) m_r[rt] = m_mem[ea[11:2]];
            end
            6'h2B: begin
                cyc = 4 + 2 * waits;
                ea  = a + simm;
                m_mem[ea[11:2]] = b;
                is_st   = 1'b1;
                st_addr = ea;
            end
            6'h04: begin
                cyc = 3 + waits;
                if (a == b) npc = npc + (simm << 2);
            end
            6'h02: begin
                cyc = 3 + waits;
                npc = {npc[31:28], ir[25:0], 2'b00};
            end
            default: halt = 1'b1;
        endcase
        if (halt) cyc = 2 + waits;
        else      m_ret = m_ret + 32'd1;
        m_pc = npc;
    endtask

    task automatic run_insn(output int cyc);
        int          exp_cyc;
        bit          exp_halt, is_st;
        logic [31:0] st_addr, prev_ret;
        prev_ret = retired;
        model_step(exp_cyc, exp_halt, is_st, st_addr);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (retired == prev_ret && !halted && cyc < 300);
        chk("cycles", 32'(cyc), 32'(exp_cyc));
        chk("halted", {31'b0, halted}, {31'b0, exp_halt});
        chk("retired", retired, m_ret);
        chk("pc", pc_dbg, m_pc);
        for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), dut.r_rf[i], m_r[i]);
        if (is_st) chk("store", mem[st_addr[11:2]], m_mem[st_addr[11:2]]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc", pc_dbg, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic gen_random();
        logic [4:0]  ra, rb, rd;
        logic [31:0] tg;
        int          k;
        clear_mem();
        for (int w = 0; w < 400; w++) begin
            ra = 5'($urandom);
            rb = 5'($urandom);
            rd = 5'($urandom);
            k  = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3: mem[w] = enc_r(ra, rb, rd, fn_tab[$urandom_range(0, 4)]);
                4, 9:       mem[w] = enc_i(6'h08, ra, rb, 16'($urandom));
                5:          mem[w] = enc_i(6'h23, 5'd0, rb, 16'h0800 + 16'(4 * $urandom_range(0, 255)));
                6:          mem[w] = enc_i(6'h2B, 5'd0, rb, 16'h0800 + 16'(4 * $urandom_range(0, 255)));
                7:          mem[w] = enc_i(6'h04, ra, ($urandom_range(0, 1) == 1) ? ra : rb,
                                           16'($urandom_range(0, 3)));
                default: begin
                    tg     = 32'(w + 1 + int'($urandom_range(0, 3)));
                    mem[w] = enc_j(tg[25:0]);
                end
            endcase
        end
        for (int i = 0; i < 256; i++) mem[512 + i] = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, total;

        // addi/addi/add, zero wait states
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
        mem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'd0);
        waits = 0;
        do_reset();
        total = 0;
        for (int i = 0; i < 3; i++) begin
            run_insn(cyc);
            total += cyc;
        end
        chk("t1_total_cycles", 32'(total), 32'd12);
        chk("t1_r3", dut.r_rf[3], 32'd12);
        chk("t1_retired", retired, 32'd3);

        // sw then lw, 3 wait states per access
        waits = 3;
        run_insn(cyc);
        chk("t2_sw_cycles", 32'(cyc), 32'd10);
        chk("t2_mem0", mem[0], 32'd12);
        run_insn(cyc);
        chk("t2_lw_cycles", 32'(cyc), 32'd11);
        chk("t2_r4", dut.r_rf[4], 32'd12);

        // branches, jump, r0 write, signed slt
        clear_mem();
        mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        mem[2]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        mem[3]  = enc_i(6'h08, 5'd0, 5'd5, 16'hFFFF);
        mem[4]  = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        mem[5]  = enc_r(5'd5, 5'd6, 5'd5, 6'h2A);
        mem[6]  = enc_r(5'd1, 5'd2, 5'd0, 6'h20);
        mem[7]  = enc_j(26'h40);
        mem[64] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        waits = 1;
        do_reset();
        run_insn(cyc);
        run_insn(cyc);
        run_insn(cyc);
        chk("t3_beq_fallthrough_pc", pc_dbg, 32'd12);
        for (int i = 0; i < 3; i++) run_insn(cyc);
        chk("t4_slt_r5", dut.r_rf[5], 32'd1);
        run_insn(cyc);
        chk("t4_r0_zero", dut.r_rf[0], 32'd0);
        run_insn(cyc);
        chk("t3_jump_pc", pc_dbg, 32'h100);
        for (int i = 0; i < 3; i++) begin
            run_insn(cyc);
            chk("t3_loop_pc", pc_dbg, 32'h100);
        end

        // illegal opcode halts two cycles after fetch
        clear_mem();
        mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        mem[1] = 32'hFC00_0000;
        waits = 0;
        do_reset();
        run_insn(cyc);
        run_insn(cyc);
        chk("t5_halt_cycles", 32'(cyc), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_halted", {31'b0, halted}, 32'd1);
            chk("t5_no_rd", {31'b0, mem_rd}, 32'd0);
            chk("t5_retired", retired, 32'd1);
        end

        // unknown funct halts too, with wait states
        clear_mem();
        mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
        waits = 2;
        do_reset();
        run_insn(cyc);
        chk("t5b_funct_halt", {31'b0, halted}, 32'd1);

        // reset while lw waits in MEMRD
        clear_mem();
        mem[0]   = enc_i(6'h23, 5'd0, 5'd7, 16'h0800);
        mem[512] = 32'hDEAD_BEEF;
        waits = 4;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            if (mem_rd && mem_addr == 32'h800) break;
            @(posedge clk); #1;
        end
        chk("t6_in_memrd", {31'b0, mem_rd && mem_addr == 32'h800}, 32'd1);
        @(posedge clk); #1;
        chk("t6_still_waiting", {31'b0, mem_rd && mem_addr == 32'h800}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_pc", pc_dbg, 32'h0);
        chk("t6_rd_in_reset", {31'b0, mem_rd}, 32'd0);
        chk("t6_r7", dut.r_rf[7], 32'd0);
        chk("t6_retired", retired, 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_fetch_rd", {31'b0, mem_rd}, 32'd1);
        chk("t6_fetch_addr", mem_addr, 32'h0);
        model_reset();
        run_insn(cyc);
        chk("t6_lw_after", dut.r_rf[7], 32'hDEAD_BEEF);

        // random program with random wait states
        gen_random();
        waits = 0;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            waits = $urandom_range(0, 2);
            run_insn(cyc);
            if (halted) break;
        end
        chk("rand_not_halted", {31'b0, halted}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
